mem_access: RTL

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// mem_access: memory-stage load/store sequencer between the pipeline and a
// two-phase data bus (address accept, then data complete).
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   req_valid          memory-stage request present, held until done
//   req_load/store     request kind; neither means no bus access
//   req_addr           byte address
//   req_msize          000 byte, 001 half, 010 word, 011 dword
//   req_unsigned       load zero-extends when 1
//   req_wd/strobe      store data and byte enables, already lane-aligned
//   dbus_valid         bus request, high while in REQ
//   dbus_addr/size     captured address and msize
//   dbus_strobe/data   captured store strobe (0 for loads) and data
//   dbus_addr_ok       bus accepted the request
//   dbus_data_ok       bus completed the transaction
//   dbus_rdata         raw 64-bit read data
//   done               one-cycle completion pulse
//   misalign           valid with done; address misaligned for msize
//   rdata              extracted load result, valid with done
//   stall              pipeline must hold (req_valid and not done)
module mem_access #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_load,
  input  logic              req_store,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_msize,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wd,
  input  logic [7:0]        req_strobe,
  output logic              dbus_valid,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [2:0]        dbus_size,
  output logic [7:0]        dbus_strobe,
  output logic [DATA_W-1:0] dbus_data,
  input  logic              dbus_addr_ok,
  input  logic              dbus_data_ok,
  input  logic [DATA_W-1:0] dbus_rdata,
  output logic              done,
  output logic              misalign,
  output logic [DATA_W-1:0] rdata,
  output logic              stall
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, nxt;

  logic        is_mem;
  logic        aligned;
  logic        uns_q;
  logic        load_q;
  logic        mis_q;
  logic        cap_ld;
  logic [63:0] ext;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic [31:0] lw;
  logic        sz_b, sz_h, sz_w, sz_d;

  assign is_mem = req_load | req_store;

  always_comb begin
    aligned = 1'b1;
    case (req_msize[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~req_addr[0];
      2'b10:   aligned = (req_addr[1:0] == 2'b00);
      default: aligned = (req_addr[2:0] == 3'b000);
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // next state
  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (req_valid)
              nxt = (is_mem && aligned) ? REQ : DONE;
      REQ:  if (dbus_addr_ok)
              nxt = dbus_data_ok ? DONE : WAIT;
      WAIT: if (dbus_data_ok) nxt = DONE;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    dbus_valid = (state == REQ);
    done       = (state == DONE);
    misalign   = (state == DONE) && mis_q;
    stall      = req_valid && (state != DONE);
  end

  // lane extraction from the captured address, not the live request
  assign lb = dbus_rdata[{dbus_addr[2:0], 3'b000} +: 8];
  assign lh = dbus_rdata[{dbus_addr[2:1], 4'b0000} +: 16];
  assign lw = dbus_rdata[{dbus_addr[2], 5'b00000} +: 32];

  assign sz_b = (dbus_size == 3'b000);
  assign sz_h = (dbus_size == 3'b001);
  assign sz_w = (dbus_size == 3'b010);
  assign sz_d = ~(sz_b | sz_h | sz_w);

  always_comb begin
    ext = dbus_rdata;
    unique case (1'b1)
      sz_b: ext = {{56{~uns_q & lb[7]}}, lb};
      sz_h: ext = {{48{~uns_q & lh[15]}}, lh};
      sz_w: ext = {{32{~uns_q & lw[31]}}, lw};
      sz_d: ext = dbus_rdata;
    endcase
  end

  // load data is taken only on the cycle that completes the transaction
  assign cap_ld = load_q && dbus_data_ok &&
                  ((state == WAIT) ||
                   ((state == REQ) && dbus_addr_ok));

  always_ff @(posedge clk) begin
    if (reset) begin
      dbus_addr   <= '0;
      dbus_size   <= '0;
      dbus_strobe <= '0;
      dbus_data   <= '0;
      uns_q       <= 1'b0;
      load_q      <= 1'b0;
      mis_q       <= 1'b0;
      rdata       <= '0;
    end else if (state == IDLE && req_valid) begin
      rdata <= '0;
      mis_q <= is_mem && !aligned;
      if (is_mem && aligned) begin
        dbus_addr   <= req_addr;
        dbus_size   <= req_msize;
        dbus_strobe <= req_load ? 8'h00 : req_strobe;
        dbus_data   <= req_wd;
        uns_q       <= req_unsigned;
        load_q      <= req_load;
      end
    end else if (cap_ld) begin
      rdata <= ext;
    end
  end

endmodule
